increment_repeater: RTL and testbench
=====================================

INCREMENT_REPEATER -- requirements
Module: increment_repeater

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept a button level change (range 1..65535).
REQ-002 SHALL have parameter HOLD_DELAY_CYCLES, default 20, cycles from the first pulse to the first auto-repeat pulse (range 2..2^24-1).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 5, cycles between consecutive auto-repeat pulses (range 2..2^24-1).
REQ-004 SHALL have port i_Clock, input, 1 bit: the single clock; all state is rising-edge.
REQ-005 SHALL have port i_Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_Button, input, 1 bit: raw, asynchronous, bouncing set button; high means pressed.
REQ-007 SHALL have port i_Enable, input, 1 bit: increment permission from control_unit o_Counters_Enable_Increment.
REQ-008 SHALL have port o_Increment_Pulse, output, 1 bit: registered, one-cycle increment strobe to the counters.
REQ-009 SHALL have port o_Button_Level, output, 1 bit: registered, debounced button level.
REQ-010 SHALL have port o_Repeating, output, 1 bit: registered, high while the FSM is in REPEAT.

Function
REQ-011 SHALL pass i_Button through a 2-flop synchronizer before any other use.
REQ-012 SHALL change o_Button_Level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the debounce counter.
REQ-013 SHALL size every counter as $clog2(max+1) bits, saturate nothing, and never wrap while counting.
REQ-014 SHALL implement FSM states IDLE, HOLD_WAIT, REPEAT, LOCKOUT.
REQ-015 IDLE: on a debounced rise with i_Enable=1, SHALL assert o_Increment_Pulse for exactly the next cycle and enter HOLD_WAIT; latency from raw press to pulse = 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-016 HOLD_WAIT: SHALL emit the next pulse exactly HOLD_DELAY_CYCLES cycles after the first pulse, then enter REPEAT.
REQ-017 REPEAT: SHALL emit one pulse every REPEAT_CYCLES cycles while the debounced level stays high.
REQ-018 On a debounced fall in HOLD_WAIT or REPEAT, SHALL return to IDLE with no pulse; a fall coinciding with a timer expiry SHALL suppress that pulse.
REQ-019 If i_Enable=0 in any state, SHALL force o_Increment_Pulse=0 and go to LOCKOUT if the debounced level is high, else to IDLE.
REQ-020 LOCKOUT: SHALL emit no pulses and SHALL go to IDLE only on a debounced fall, so that raising i_Enable while the button is held never creates a pulse.
REQ-021 SHALL ignore a debounced rise in IDLE while i_Enable=0 and enter LOCKOUT instead.
REQ-022 SHALL never assert o_Increment_Pulse on two consecutive cycles.

Reset
REQ-023 While i_Reset_n=0, SHALL drive all outputs 0 immediately, put the FSM in IDLE, and clear the synchronizer, debounce and timing counters.
REQ-024 After reset release with the button held, SHALL treat the held button as a fresh press and pulse after 2 + DEBOUNCE_CYCLES + 1 cycles if i_Enable=1.

Structure
REQ-025 SHALL place the FSM state encoding and the default parameter values in the shared package clock_pkg.
REQ-026 SHALL place the synchronizer and debouncer in the sub-module button_debouncer (parameter DEBOUNCE_CYCLES; output debounced level plus one-cycle rise and fall strobes).

Verification (DEBOUNCE=4, HOLD=20, REPEAT=5, i_Enable=1 unless stated)
REQ-027 A 3-cycle high glitch on i_Button SHALL produce no pulse and keep o_Button_Level=0.
REQ-028 A clean press held 10 cycles SHALL produce exactly one pulse, 7 cycles after the press; release SHALL produce no pulse.
REQ-029 A press held 60 cycles SHALL produce pulses at t, t+20, t+25, t+30, ...; o_Repeating SHALL be high from t+20 until 7 cycles after release.
REQ-030 A press with i_Enable=0, then i_Enable=1 while still held, SHALL produce 0 pulses; release and re-press SHALL produce 1 pulse.
REQ-031 A release timed so that the debounced fall lands on a repeat-expiry cycle SHALL produce no pulse on that cycle and return the FSM to IDLE.
REQ-032 Asserting i_Reset_n=0 mid-REPEAT SHALL drive all outputs 0 asynchronously; after release with the button held, one pulse SHALL follow 7 cycles later.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and default timing for the set-button increment repeater.
package clock_pkg;

    localparam int DEF_DEBOUNCE_CYCLES   = 4;
    localparam int DEF_HOLD_DELAY_CYCLES = 20;
    localparam int DEF_REPEAT_CYCLES     = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEAT    = 2'd2,
        LOCKOUT   = 2'd3
    } rep_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus run-length debouncer; level changes after DEBOUNCE_CYCLES
// consecutive disagreeing samples, with one-cycle rise/fall strobes aligned to the change.
module button_debouncer
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], button};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] != level) begin
                // Last disagreeing sample of the run flips the level and restarts the count.
                if (cnt == CNT_LAST) begin
                    level <= sync[1];
                    rise  <= sync[1];
                    fall  <= ~sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/increment_repeater.sv
// Debounced set button to increment strobes: first pulse one cycle after the debounced rise,
// then auto-repeat after HOLD_DELAY_CYCLES and every REPEAT_CYCLES while held and enabled.
module increment_repeater
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_DELAY_CYCLES = DEF_HOLD_DELAY_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic i_Clock,
    input  logic i_Reset_n,
    input  logic i_Button,
    input  logic i_Enable,
    output logic o_Increment_Pulse,
    output logic o_Button_Level,
    output logic o_Repeating
);

    localparam int TMR_W = $clog2(max_int(HOLD_DELAY_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_DELAY_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

    rep_state_t       state;
    logic [TMR_W-1:0] timer;
    logic             level;
    logic             rise;
    logic             fall;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (i_Clock),
        .rst_n  (i_Reset_n),
        .button (i_Button),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    assign o_Button_Level = level;

    // Timer counts cycles since the last pulse; it is zero whenever not timing.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state             <= IDLE;
            timer             <= '0;
            o_Increment_Pulse <= 1'b0;
            o_Repeating       <= 1'b0;
        end else begin
            o_Increment_Pulse <= 1'b0;
            o_Repeating       <= 1'b0;
            timer             <= '0;
            if (!i_Enable) begin
                state <= level ? LOCKOUT : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            o_Increment_Pulse <= 1'b1;
                            state             <= HOLD_WAIT;
                        end
                    end
                    HOLD_WAIT: begin
                        if (fall) begin
                            state <= IDLE;
                        end else if (timer == HOLD_LAST) begin
                            o_Increment_Pulse <= 1'b1;
                            o_Repeating       <= 1'b1;
                            state             <= REPEAT;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    REPEAT: begin
                        // A release landing on an expiry cycle wins over the pulse.
                        if (fall) begin
                            state <= IDLE;
                        end else begin
                            o_Repeating <= 1'b1;
                            if (timer == REPEAT_LAST) begin
                                o_Increment_Pulse <= 1'b1;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                    LOCKOUT: begin
                        if (fall) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_increment_repeater.sv
// Bench for increment_repeater: directed and random button/enable windows against a press-interval model.
module tb_increment_repeater;

    localparam int D    = 4;
    localparam int H    = 20;
    localparam int R    = 5;
    localparam int MAXC = 160;
    localparam int NW   = 150;

    logic i_Clock = 1'b0;
    logic i_Reset_n;
    logic i_Button;
    logic i_Enable;
    logic o_Increment_Pulse;
    logic o_Button_Level;
    logic o_Repeating;

    int checks = 0;
    int errors = 0;

    logic btn_s [MAXC];
    logic en_s  [MAXC];
    logic obs_p [MAXC];
    logic obs_l [MAXC];
    logic obs_r [MAXC];
    logic exp_p [MAXC];
    logic exp_l [MAXC];
    logic exp_r [MAXC];

    increment_repeater #(
        .DEBOUNCE_CYCLES  (D),
        .HOLD_DELAY_CYCLES(H),
        .REPEAT_CYCLES    (R)
    ) dut (
        .i_Clock          (i_Clock),
        .i_Reset_n        (i_Reset_n),
        .i_Button         (i_Button),
        .i_Enable         (i_Enable),
        .o_Increment_Pulse(o_Increment_Pulse),
        .o_Button_Level   (o_Button_Level),
        .o_Repeating      (o_Repeating)
    );

    always #5 i_Clock = ~i_Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    task automatic clear_stim;
        for (int c = 0; c < MAXC; c++) begin
            btn_s[c] = 1'b0;
            en_s[c]  = 1'b1;
        end
    endtask

    // Leaves the bench just after a rising edge with reset released; that cycle is cycle 0.
    task automatic do_reset;
        i_Button  = btn_s[0];
        i_Enable  = en_s[0];
        i_Reset_n = 1'b0;
        repeat (3) @(posedge i_Clock);
        #1;
        i_Reset_n = 1'b1;
    endtask

    task automatic play(input int n);
        for (int c = 0; c < n; c++) begin
            i_Button = btn_s[c];
            i_Enable = en_s[c];
            @(negedge i_Clock);
            obs_p[c] = o_Increment_Pulse;
            obs_l[c] = o_Button_Level;
            obs_r[c] = o_Repeating;
            @(posedge i_Clock);
            #1;
        end
    endtask

    // Reference: debounced level is the raw button delayed two cycles, flipping once D
    // consecutive samples disagree. Each debounced-high interval starting with enable high
    // yields pulses at rise+1, +H, then every R, while still high and enable stayed high.
    task automatic model(input int n);
        int  idx, b, j0, p, k, last;
        logic s;
        bit  all_diff;
        for (int c = 0; c < MAXC; c++) begin
            exp_p[c] = 1'b0;
            exp_l[c] = 1'b0;
            exp_r[c] = 1'b0;
        end
        for (int c = 0; c < n - 1; c++) begin
            all_diff = 1'b1;
            for (int q = 0; q < D; q++) begin
                idx = c - 2 - q;
                s = (idx >= 0) ? btn_s[idx] : 1'b0;
                if (s == exp_l[c]) all_diff = 1'b0;
            end
            exp_l[c+1] = all_diff ? ~exp_l[c] : exp_l[c];
        end
        for (int a = 1; a < n; a++) begin
            if (exp_l[a] && !exp_l[a-1] && en_s[a]) begin
                b = n + 1000;
                for (int c = a + 1; c < n; c++) if (!exp_l[c]) begin b = c; break; end
                j0 = n + 1000;
                for (int c = a; c < n; c++) if (!en_s[c]) begin j0 = c; break; end
                p = a + 1;
                k = 0;
                while (p < n && p <= b && p <= j0) begin
                    exp_p[p] = 1'b1;
                    if (k == 1) begin
                        last = (b < j0) ? b : j0;
                        for (int c = p; c <= last && c < n; c++) exp_r[c] = 1'b1;
                    end
                    p = p + ((k == 0) ? H : R);
                    k++;
                end
            end
        end
    endtask

    task automatic test_reset;
        i_Reset_n = 1'b0;
        i_Button  = 1'b1;
        i_Enable  = 1'b1;
        repeat (3) @(posedge i_Clock);
        @(negedge i_Clock);
        checks += 3;
        if (o_Increment_Pulse !== 1'b0) begin errors++; $display("FAIL reset pulse: got %b want 0", o_Increment_Pulse); end
        if (o_Button_Level !== 1'b0) begin errors++; $display("FAIL reset level: got %b want 0", o_Button_Level); end
        if (o_Repeating !== 1'b0) begin errors++; $display("FAIL reset repeating: got %b want 0", o_Repeating); end
    endtask

    task automatic test_glitch;
        int np, nl;
        clear_stim();
        for (int c = 2; c < 5; c++) btn_s[c] = 1'b1;
        do_reset();
        play(30);
        model(30);
        np = 0;
        nl = 0;
        for (int c = 0; c < 30; c++) begin
            checks += 3;
            if (obs_p[c] !== exp_p[c]) begin errors++; $display("FAIL glitch pulse c%0d: got %b want %b", c, obs_p[c], exp_p[c]); end
            if (obs_l[c] !== exp_l[c]) begin errors++; $display("FAIL glitch level c%0d: got %b want %b", c, obs_l[c], exp_l[c]); end
            if (obs_r[c] !== exp_r[c]) begin errors++; $display("FAIL glitch repeating c%0d: got %b want %b", c, obs_r[c], exp_r[c]); end
            if (obs_p[c] === 1'b1) np++;
            if (obs_l[c] === 1'b1) nl++;
        end
        checks += 2;
        if (np != 0) begin errors++; $display("FAIL glitch pulse_count: got %0d want 0", np); end
        if (nl != 0) begin errors++; $display("FAIL glitch level_high_cycles: got %0d want 0", nl); end
    endtask

    task automatic test_single_press;
        int np, first;
        clear_stim();
        for (int c = 0; c < 10; c++) btn_s[c] = 1'b1;
        do_reset();
        play(40);
        model(40);
        np = 0;
        first = -1;
        for (int c = 0; c < 40; c++) begin
            checks += 3;
            if (obs_p[c] !== exp_p[c]) begin errors++; $display("FAIL single pulse c%0d: got %b want %b", c, obs_p[c], exp_p[c]); end
            if (obs_l[c] !== exp_l[c]) begin errors++; $display("FAIL single level c%0d: got %b want %b", c, obs_l[c], exp_l[c]); end
            if (obs_r[c] !== exp_r[c]) begin errors++; $display("FAIL single repeating c%0d: got %b want %b", c, obs_r[c], exp_r[c]); end
            if (obs_p[c] === 1'b1) begin np++; if (first < 0) first = c; end
        end
        checks += 2;
        if (np != 1) begin errors++; $display("FAIL single pulse_count: got %0d want 1", np); end
        if (first != 7) begin errors++; $display("FAIL single latency: got %0d want 7", first); end
    endtask

    task automatic test_hold_repeat;
        int np;
        clear_stim();
        for (int c = 0; c < 60; c++) btn_s[c] = 1'b1;
        do_reset();
        play(90);
        model(90);
        np = 0;
        for (int c = 0; c < 90; c++) begin
            checks += 3;
            if (obs_p[c] !== exp_p[c]) begin errors++; $display("FAIL hold pulse c%0d: got %b want %b", c, obs_p[c], exp_p[c]); end
            if (obs_l[c] !== exp_l[c]) begin errors++; $display("FAIL hold level c%0d: got %b want %b", c, obs_l[c], exp_l[c]); end
            if (obs_r[c] !== exp_r[c]) begin errors++; $display("FAIL hold repeating c%0d: got %b want %b", c, obs_r[c], exp_r[c]); end
            if (obs_p[c] === 1'b1) np++;
        end
        checks += 5;
        if (np != 9) begin errors++; $display("FAIL hold pulse_count: got %0d want 9", np); end
        if (obs_p[27] !== 1'b1) begin errors++; $display("FAIL hold first_repeat c27: got %b want 1", obs_p[27]); end
        if (obs_r[26] !== 1'b0) begin errors++; $display("FAIL hold repeating c26: got %b want 0", obs_r[26]); end
        if (obs_r[66] !== 1'b1) begin errors++; $display("FAIL hold repeating c66: got %b want 1", obs_r[66]); end
        if (obs_r[67] !== 1'b0) begin errors++; $display("FAIL hold repeating c67: got %b want 0", obs_r[67]); end
    endtask

    task automatic test_enable_lockout;
        int early, np;
        clear_stim();
        for (int c = 0; c < 10; c++) en_s[c] = 1'b0;
        for (int c = 0; c < 30; c++) btn_s[c] = 1'b1;
        for (int c = 40; c < 50; c++) btn_s[c] = 1'b1;
        do_reset();
        play(75);
        model(75);
        early = 0;
        np = 0;
        for (int c = 0; c < 75; c++) begin
            checks += 3;
            if (obs_p[c] !== exp_p[c]) begin errors++; $display("FAIL lockout pulse c%0d: got %b want %b", c, obs_p[c], exp_p[c]); end
            if (obs_l[c] !== exp_l[c]) begin errors++; $display("FAIL lockout level c%0d: got %b want %b", c, obs_l[c], exp_l[c]); end
            if (obs_r[c] !== exp_r[c]) begin errors++; $display("FAIL lockout repeating c%0d: got %b want %b", c, obs_r[c], exp_r[c]); end
            if (obs_p[c] === 1'b1) begin np++; if (c < 40) early++; end
        end
        checks += 3;
        if (early != 0) begin errors++; $display("FAIL lockout held_pulses: got %0d want 0", early); end
        if (np != 1) begin errors++; $display("FAIL lockout pulse_count: got %0d want 1", np); end
        if (obs_p[47] !== 1'b1) begin errors++; $display("FAIL lockout repress_pulse c47: got %b want 1", obs_p[47]); end
    endtask

    task automatic test_fall_on_expiry;
        int np;
        clear_stim();
        for (int c = 0; c < 30; c++) btn_s[c] = 1'b1;
        do_reset();
        play(60);
        model(60);
        np = 0;
        for (int c = 0; c < 60; c++) begin
            checks += 3;
            if (obs_p[c] !== exp_p[c]) begin errors++; $display("FAIL expiry pulse c%0d: got %b want %b", c, obs_p[c], exp_p[c]); end
            if (obs_l[c] !== exp_l[c]) begin errors++; $display("FAIL expiry level c%0d: got %b want %b", c, obs_l[c], exp_l[c]); end
            if (obs_r[c] !== exp_r[c]) begin errors++; $display("FAIL expiry repeating c%0d: got %b want %b", c, obs_r[c], exp_r[c]); end
            if (obs_p[c] === 1'b1) np++;
        end
        checks += 4;
        if (obs_p[37] !== 1'b0) begin errors++; $display("FAIL expiry suppressed c37: got %b want 0", obs_p[37]); end
        if (obs_r[36] !== 1'b1) begin errors++; $display("FAIL expiry repeating c36: got %b want 1", obs_r[36]); end
        if (obs_r[37] !== 1'b0) begin errors++; $display("FAIL expiry idle c37: got %b want 0", obs_r[37]); end
        if (np != 3) begin errors++; $display("FAIL expiry pulse_count: got %0d want 3", np); end
    endtask

    task automatic test_random;
        int c, len;
        logic v, e;
        for (int w = 0; w < 4; w++) begin
            clear_stim();
            c = 0;
            v = 1'($urandom_range(0, 1));
            while (c < NW) begin
                len = $urandom_range(1, 40);
                for (int i = 0; i < len && c < NW; i++) begin btn_s[c] = v; c++; end
                v = ~v;
            end
            c = 0;
            while (c < NW) begin
                len = $urandom_range(1, 30);
                e = ($urandom_range(0, 5) != 0);
                for (int i = 0; i < len && c < NW; i++) begin en_s[c] = e; c++; end
            end
            do_reset();
            play(NW);
            model(NW);
            for (int t = 0; t < NW; t++) begin
                checks += 3;
                if (obs_p[t] !== exp_p[t]) begin errors++; $display("FAIL random%0d pulse c%0d: got %b want %b", w, t, obs_p[t], exp_p[t]); end
                if (obs_l[t] !== exp_l[t]) begin errors++; $display("FAIL random%0d level c%0d: got %b want %b", w, t, obs_l[t], exp_l[t]); end
                if (obs_r[t] !== exp_r[t]) begin errors++; $display("FAIL random%0d repeating c%0d: got %b want %b", w, t, obs_r[t], exp_r[t]); end
                if (t > 0) begin
                    checks++;
                    if (obs_p[t] === 1'b1 && obs_p[t-1] === 1'b1) begin
                        errors++;
                        $display("FAIL random%0d back_to_back c%0d: got 2 consecutive pulses want at most 1", w, t);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset;
        int first;
        clear_stim();
        for (int c = 0; c < MAXC; c++) btn_s[c] = 1'b1;
        do_reset();
        play(40);
        checks += 2;
        if (o_Repeating !== 1'b1) begin errors++; $display("FAIL areset pre_repeating: got %b want 1", o_Repeating); end
        if (o_Button_Level !== 1'b1) begin errors++; $display("FAIL areset pre_level: got %b want 1", o_Button_Level); end
        #3;
        i_Reset_n = 1'b0;
        #1;
        checks += 3;
        if (o_Increment_Pulse !== 1'b0) begin errors++; $display("FAIL areset pulse: got %b want 0", o_Increment_Pulse); end
        if (o_Button_Level !== 1'b0) begin errors++; $display("FAIL areset level: got %b want 0", o_Button_Level); end
        if (o_Repeating !== 1'b0) begin errors++; $display("FAIL areset repeating: got %b want 0", o_Repeating); end
        do_reset();
        play(20);
        model(20);
        first = -1;
        for (int c = 0; c < 20; c++) begin
            checks += 3;
            if (obs_p[c] !== exp_p[c]) begin errors++; $display("FAIL areset pulse c%0d: got %b want %b", c, obs_p[c], exp_p[c]); end
            if (obs_l[c] !== exp_l[c]) begin errors++; $display("FAIL areset level c%0d: got %b want %b", c, obs_l[c], exp_l[c]); end
            if (obs_r[c] !== exp_r[c]) begin errors++; $display("FAIL areset repeating c%0d: got %b want %b", c, obs_r[c], exp_r[c]); end
            if (obs_p[c] === 1'b1 && first < 0) first = c;
        end
        checks++;
        if (first != 7) begin errors++; $display("FAIL areset held_latency: got %0d want 7", first); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single_press();
        test_hold_repeat();
        test_enable_lockout();
        test_fall_on_expiry();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
